// File: rtl/mux_nx1_stream_rr.sv
// Purpose : N-to-1 packet-aware stream mux, round-robin or fixed-select arbitration.
// Latency : one cycle from input handshake to registered out_* beat; 1 beat/cycle sustained.
// Backpressure: in_ready follows the output register's load slot; a stalled sink drops every in_ready.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   mode, sel                  0 = round-robin, 1 = fixed channel sel (sampled only between packets)
//   in_data/in_valid/in_last   packed per-channel stream inputs, channel i at [i*WIDTH +: WIDTH]
//   in_ready                   per-channel ready, combinational, at most one bit high
//   out_data/out_last/out_ch   registered output beat and its source channel
//   out_valid/out_ready        output handshake
module mux_nx1_stream_rr #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    logic [SEL_W-1:0] lock_ch;
    logic             lock_rr;    // arbitration mode captured when the current packet started
    logic [SEL_W-1:0] rr_ptr;

    logic [SEL_W-1:0] grant_ch;
    logic [SEL_W-1:0] cand;
    logic             grant_en;
    logic             load;
    logic             xfer;
    logic             xfer_last;
    logic             pkt_rr;

    logic [WIDTH-1:0] ch_dat [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_dat[g] = in_data[g*WIDTH +: WIDTH];
    end

    // Arbitration. The round-robin scan runs from the farthest offset down to
    // offset 0 so the nearest valid channel after rr_ptr is the last writer.
    always_comb begin
        grant_ch = '0;
        grant_en = 1'b0;
        cand     = '0;
        if (state == LOCKED) begin
            grant_ch = lock_ch;
            grant_en = 1'b1;
        end else if (mode) begin
            grant_ch = sel;
            grant_en = (int'(sel) < NUM_CH);
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                cand = SEL_W'((int'(rr_ptr) + k) % NUM_CH);
                if (in_valid[cand]) begin
                    grant_ch = cand;
                    grant_en = 1'b1;
                end
            end
        end
    end

    always_comb begin
        load     = !out_valid || out_ready;
        in_ready = '0;
        if (load && grant_en) begin
            in_ready[grant_ch] = 1'b1;
        end
        xfer      = |(in_valid & in_ready);
        xfer_last = in_last[grant_ch];
        // A packet's closing beat updates rr_ptr according to the mode it started in,
        // since mode is not looked at while locked.
        pkt_rr    = (state == IDLE) ? !mode : lock_rr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            rr_ptr    <= '0;
            state     <= IDLE;
            lock_ch   <= '0;
            lock_rr   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= ch_dat[grant_ch];
                    out_last <= xfer_last;
                    out_ch   <= grant_ch;
                end
            end

            if (xfer) begin
                case (state)
                    IDLE: begin
                        if (!xfer_last) begin
                            state   <= LOCKED;
                            lock_ch <= grant_ch;
                            lock_rr <= !mode;
                        end
                    end
                    LOCKED: begin
                        if (xfer_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (xfer_last && pkt_rr) begin
                    rr_ptr <= SEL_W'((int'(grant_ch) + 1) % NUM_CH);
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_stream_rr.sv
module tb_mux_nx1_stream_rr;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_last;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_last;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    int errors = 0;
    int checks = 0;

    // Expected beats in output order, packed as {ch, data, last}.
    logic [SEL_W+WIDTH:0] exp_q [$];

    mux_nx1_stream_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic v, input logic [WIDTH-1:0] d, input logic l);
        in_valid[i]               = v;
        in_data[i*WIDTH +: WIDTH] = d;
        in_last[i]                = l;
    endtask

    task automatic push(input logic [SEL_W-1:0] ch, input logic [WIDTH-1:0] d, input logic l);
        exp_q.push_back({ch, d, l});
    endtask

    // Scoreboard: every completed output handshake must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("sb_beat", 32'({out_ch, out_data, out_last}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: fixed mode, sel=2, single beat
        mode = 1'b1; sel = 2'd2; out_ready = 1'b1;
        set_ch(2, 1'b1, 8'hA5, 1'b1);
        push(2'd2, 8'hA5, 1'b1);
        @(negedge clk);
        chk("t1_in_ready", 32'(in_ready), 32'h4);
        tick();
        set_ch(2, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data",  32'(out_data),  32'hA5);
        chk("t1_out_ch",    32'(out_ch),    32'd2);
        tick();
        mode = 1'b0;

        // 2: round-robin over four always-valid single-beat channels
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int k = 0; k < 5; k++) push(SEL_W'(k % NUM_CH), 8'(8'h10 + (k % NUM_CH)), 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_in_ready", 32'(in_ready), 32'(1 << (k % NUM_CH)));
            if (k > 0) chk("t2_no_bubble", 32'(out_valid), 32'd1);
            tick();
        end
        in_valid = '0;
        tick();

        // 3: packet lock on ch1 with ch0/ch3 competing; rr_ptr=1 here
        set_ch(0, 1'b1, 8'h20, 1'b1);
        set_ch(3, 1'b1, 8'h23, 1'b1);
        set_ch(1, 1'b1, 8'h31, 1'b0);
        push(2'd1, 8'h31, 1'b0);
        push(2'd1, 8'h32, 1'b0);
        push(2'd1, 8'h33, 1'b1);
        push(2'd3, 8'h23, 1'b1);
        @(negedge clk);
        chk("t3_first_grant", 32'(in_ready), 32'h2);
        tick();
        set_ch(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t3_lock_while_idle_src", 32'(in_ready), 32'h2);
        tick();
        set_ch(1, 1'b1, 8'h32, 1'b0);
        @(negedge clk);
        chk("t3_lock_beat2", 32'(in_ready), 32'h2);
        tick();
        set_ch(1, 1'b1, 8'h33, 1'b1);
        tick();
        set_ch(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t3_rr_after_lock", 32'(in_ready), 32'h8);
        tick();
        in_valid = '0;
        tick();

        // 4: backpressure for five cycles with a second beat waiting; rr_ptr=0
        set_ch(2, 1'b1, 8'h44, 1'b1);
        push(2'd2, 8'h44, 1'b1);
        push(2'd0, 8'h40, 1'b1);
        tick();
        set_ch(2, 1'b0, 8'h00, 1'b0);
        set_ch(0, 1'b1, 8'h40, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_stall_in_ready",  32'(in_ready),  32'd0);
            chk("t4_stall_out_data",  32'(out_data),  32'h44);
            chk("t4_stall_out_ch",    32'(out_ch),    32'd2);
            chk("t4_stall_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_grant", 32'(in_ready), 32'h1);
        tick();
        set_ch(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t4_drain_fill_valid", 32'(out_valid), 32'd1);
        chk("t4_drain_fill_data",  32'(out_data),  32'h40);
        tick();

        // 5: reset in the middle of a ch2 packet; rr_ptr=1 before reset
        set_ch(2, 1'b1, 8'h51, 1'b0);
        tick();
        out_ready = 1'b0;
        set_ch(2, 1'b1, 8'h52, 1'b0);
        @(negedge clk);
        chk("t5_held_valid", 32'(out_valid), 32'd1);
        chk("t5_held_data",  32'(out_data),  32'h51);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_out_data",  32'(out_data),  32'd0);
        set_ch(2, 1'b1, 8'h62, 1'b1);
        set_ch(0, 1'b1, 8'h60, 1'b1);
        out_ready = 1'b1;
        push(2'd0, 8'h60, 1'b1);
        push(2'd2, 8'h62, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_rr_restart", 32'(in_ready), 32'h1);
        tick();
        set_ch(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t5_rr_next", 32'(in_ready), 32'h4);
        tick();
        set_ch(2, 1'b0, 8'h00, 1'b0);
        tick();

        // 6: fixed mode, sel changes mid-packet on ch0; rr_ptr=3 must survive
        mode = 1'b1; sel = 2'd0;
        set_ch(0, 1'b1, 8'h70, 1'b0);
        set_ch(3, 1'b1, 8'h7F, 1'b1);
        push(2'd0, 8'h70, 1'b0);
        push(2'd0, 8'h71, 1'b0);
        push(2'd0, 8'h72, 1'b1);
        push(2'd3, 8'h7F, 1'b1);
        @(negedge clk);
        chk("t6_fixed_grant", 32'(in_ready), 32'h1);
        tick();
        sel = 2'd3;
        set_ch(0, 1'b1, 8'h71, 1'b0);
        @(negedge clk);
        chk("t6_sel_ignored", 32'(in_ready), 32'h1);
        tick();
        set_ch(0, 1'b1, 8'h72, 1'b1);
        tick();
        set_ch(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t6_new_sel", 32'(in_ready), 32'h8);
        tick();
        set_ch(3, 1'b0, 8'h00, 1'b0);
        mode = 1'b0;
        set_ch(1, 1'b1, 8'h81, 1'b1);
        set_ch(3, 1'b1, 8'h83, 1'b1);
        push(2'd3, 8'h83, 1'b1);
        @(negedge clk);
        chk("t6_rr_ptr_kept", 32'(in_ready), 32'h8);
        tick();
        in_valid = '0;
        tick();
        tick();

        @(negedge clk);
        chk("sb_all_beats_seen", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
